// File: rtl/ped_request_conditioner.sv
// ---------------------------------------------------------------------------
// ped_request_conditioner
//   Upstream stage of the traffic light controller. Turns the two raw
//   pedestrian push-buttons into the controller's Sa/Sb "end this green"
//   requests. Each channel:
//     - synchronises and debounces its button,
//     - latches a press (walk-wait lamp pend_x),
//     - presents the request on Sx only once its road's green has been on
//       for at least MIN_GREEN cycles,
//     - withdraws the request when that green phase ends.
//
// Ports (top level)
//   clk     in   system clock, rising edge
//   reset   in   asynchronous, active-high reset
//   btn_a   in   raw pedestrian button A (asynchronous, active-high)
//   btn_b   in   raw pedestrian button B (asynchronous, active-high)
//   Ga      in   road A green lamp fed back from the controller
//   Gb      in   road B green lamp fed back from the controller
//   Sa      out  request: end road A green
//   Sb      out  request: end road B green
//   pend_a  out  request A latched but not yet presented
//   pend_b  out  request B latched but not yet presented
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// ped_request_channel
//   One complete button-to-request path. The top level instantiates two
//   identical, independent copies.
//
// Ports
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   i_btn    in   raw button level
//   i_green  in   this road's green lamp (feedback)
//   o_req    out  request presented to the controller
//   o_pend   out  request latched, waiting for minimum green
// ---------------------------------------------------------------------------
module ped_request_channel #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int MIN_GREEN    = 30,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  input  logic i_green,
  output logic o_req,
  output logic o_pend
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] GREEN_MIN = CNT_W'(MIN_GREEN);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PEND   = 2'd1;
  localparam logic [1:0] ST_ASSERT = 2'd2;

  logic             r_sync1;
  logic             r_btn_s;
  logic             r_deb;
  logic             r_deb_q;
  logic [CNT_W-1:0] r_deb_cnt;
  logic [CNT_W-1:0] r_g_cnt;
  logic             r_green_q;
  logic [1:0]       r_state;
  logic             r_req;
  logic             r_pend;

  logic             w_press;
  logic             w_g_ok;
  logic             w_g_fall;
  logic [1:0]       w_state_nxt;

  // Two-flop synchroniser: the first stage may go metastable, only the
  // second stage is used by logic.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, as real hardware does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_btn_s <= r_sync1;
    end
  end

  // Debounce: the synchronised level must differ from the accepted level
  // for DEBOUNCE_CYC consecutive cycles before it is taken. Any return to
  // the accepted level restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
    end else if (r_btn_s == r_deb) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_LAST) begin
      r_deb     <= r_btn_s;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  // r_deb_q only exists to form the one-cycle press strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb_q <= 1'b0;
    end else begin
      r_deb_q <= r_deb;
    end
  end

  assign w_press = r_deb & ~r_deb_q;

  // Green timer saturates so a long green never wraps back below MIN_GREEN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_g_cnt   <= '0;
      r_green_q <= 1'b0;
    end else begin
      r_green_q <= i_green;
      if (!i_green) begin
        r_g_cnt <= '0;
      end else if (r_g_cnt < GREEN_MIN) begin
        r_g_cnt <= r_g_cnt + 1'b1;
      end
    end
  end

  assign w_g_ok   = (r_g_cnt >= GREEN_MIN) && i_green;
  assign w_g_fall = r_green_q & ~i_green;

  // Request FSM. At most one request is outstanding; extra presses are
  // absorbed, except that a press coinciding with the end of the green
  // that served the previous request is kept as a new pending request.
  // NOTE: w_state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          w_state_nxt = w_g_ok ? ST_ASSERT : ST_PEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PEND: begin
        w_state_nxt = w_g_ok ? ST_ASSERT : ST_PEND;
      end
      ST_ASSERT: begin
        if (w_g_fall) begin
          w_state_nxt = w_press ? ST_PEND : ST_IDLE;
        end else begin
          w_state_nxt = ST_ASSERT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are flops loaded from the next-state decode, so they are
  // glitch-free and change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == ST_ASSERT);
      r_pend  <= (w_state_nxt == ST_PEND);
    end
  end

  assign o_req  = r_req;
  assign o_pend = r_pend;

endmodule

module ped_request_conditioner #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int MIN_GREEN    = 30,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_a,
  input  logic btn_b,
  input  logic Ga,
  input  logic Gb,
  output logic Sa,
  output logic Sb,
  output logic pend_a,
  output logic pend_b
);

  ped_request_channel #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .MIN_GREEN   (MIN_GREEN),
    .CNT_W       (CNT_W)
  ) u_chan_a (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_a),
    .i_green(Ga),
    .o_req  (Sa),
    .o_pend (pend_a)
  );

  ped_request_channel #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .MIN_GREEN   (MIN_GREEN),
    .CNT_W       (CNT_W)
  ) u_chan_b (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_b),
    .i_green(Gb),
    .o_req  (Sb),
    .o_pend (pend_b)
  );

endmodule

// File: tb/tb_ped_request_conditioner.sv
// ---------------------------------------------------------------------------
// tb_ped_request_conditioner
//   Directed scenarios followed by a randomised run with a toy controller
//   closing the loop on Ga/Gb. A cycle-level reference model, phrased in
//   terms of sample windows, green run lengths and request flags, predicts
//   Sa/Sb/pend_a/pend_b every cycle.
// ---------------------------------------------------------------------------
module tb_ped_request_conditioner;

  localparam int DEB  = 4;
  localparam int MING = 10;

  logic clk;
  logic reset;
  logic btn_a, btn_b, Ga, Gb;
  logic Sa, Sb, pend_a, pend_b;

  int checks = 0;
  int errors = 0;

  ped_request_conditioner #(
    .DEBOUNCE_CYC(DEB),
    .MIN_GREEN   (MING),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn_a (btn_a),
    .btn_b (btn_b),
    .Ga    (Ga),
    .Gb    (Gb),
    .Sa    (Sa),
    .Sb    (Sb),
    .pend_a(pend_a),
    .pend_b(pend_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_s1   [2];
  bit m_s    [2];
  bit m_win  [2][DEB];
  bit m_deb  [2];
  bit m_press[2];
  bit m_lastg[2];
  bit m_out  [2];   // latched, waiting
  bit m_pres [2];   // presented to controller
  int m_run  [2];   // consecutive cycles of green

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_s1[ch] = 0; m_s[ch] = 0; m_deb[ch] = 0; m_press[ch] = 0;
      m_lastg[ch] = 0; m_out[ch] = 0; m_pres[ch] = 0; m_run[ch] = 0;
      for (int i = 0; i < DEB; i++) m_win[ch][i] = 0;
    end
  endtask

  // One clock edge of the model, using the input values held across it.
  task automatic model_update();
    if (reset) begin
      model_reset();
      return;
    end
    for (int ch = 0; ch < 2; ch++) begin
      bit g, raw, gok, gfall, pr, flip;
      g     = (ch == 0) ? Ga : Gb;
      raw   = (ch == 0) ? btn_a : btn_b;
      gok   = (m_run[ch] >= MING) && g;
      gfall = m_lastg[ch] && !g;
      pr    = m_press[ch];
      if (m_pres[ch]) begin
        if (gfall) begin
          m_pres[ch] = 0;
          m_out[ch]  = pr;
        end
      end else if (m_out[ch]) begin
        if (gok) begin
          m_out[ch]  = 0;
          m_pres[ch] = 1;
        end
      end else if (pr) begin
        if (gok) m_pres[ch] = 1;
        else     m_out[ch]  = 1;
      end
      m_run[ch]   = g ? m_run[ch] + 1 : 0;
      m_lastg[ch] = g;
      // The debounced level flips once the last DEB synchronised samples
      // all disagree with it.
      for (int i = DEB - 1; i > 0; i--) m_win[ch][i] = m_win[ch][i-1];
      m_win[ch][0] = m_s[ch];
      flip = 1;
      for (int i = 0; i < DEB; i++) if (m_win[ch][i] == m_deb[ch]) flip = 0;
      m_press[ch] = flip && !m_deb[ch];
      if (flip) m_deb[ch] = !m_deb[ch];
      m_s[ch]  = m_s1[ch];
      m_s1[ch] = raw;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Advance n cycles; inputs change only at the negedge, outputs are
  // compared with the model at the negedge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_update();
      @(negedge clk);
      check("model_Sa",     Sa,     m_pres[0]);
      check("model_Sb",     Sb,     m_pres[1]);
      check("model_pend_a", pend_a, m_out[0]);
      check("model_pend_b", pend_b, m_out[1]);
    end
  endtask

  initial begin
    int road;
    bit red;
    bit sx;

    reset = 1'b1;
    btn_a = 1'b0; btn_b = 1'b0; Ga = 1'b0; Gb = 1'b0;
    model_reset();
    step(2);
    check("rst_Sa", Sa, 1'b0);
    check("rst_pend_a", pend_a, 1'b0);
    reset = 1'b0;

    // 1: asynchronous reset while both requests are presented
    Ga = 1; Gb = 1; btn_a = 1; btn_b = 1;
    step(20);
    check("t1_Sa_before", Sa, 1'b1);
    check("t1_Sb_before", Sb, 1'b1);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("t1_Sa_async", Sa, 1'b0);
    check("t1_Sb_async", Sb, 1'b0);
    check("t1_pend_a_async", pend_a, 1'b0);
    check("t1_pend_b_async", pend_b, 1'b0);
    btn_a = 0; btn_b = 0; Ga = 0; Gb = 0;
    @(negedge clk);
    reset = 1'b0;
    step(10);
    check("t1_Sa_after", Sa, 1'b0);
    check("t1_pend_a_after", pend_a, 1'b0);

    // 2: bouncing button never produces a press
    for (int i = 0; i < 5; i++) begin
      btn_a = 1; step(2);
      check("t2_pend_a", pend_a, 1'b0);
      btn_a = 0; step(2);
      check("t2_Sa", Sa, 1'b0);
    end
    step(8);
    check("t2_pend_a_end", pend_a, 1'b0);

    // 3: clean press with minimum green already met -> straight to Sa
    Ga = 1; step(12);
    btn_a = 1; step(6);
    check("t3_Sa_c6", Sa, 1'b0);
    check("t3_pend_c6", pend_a, 1'b0);
    step(1);
    check("t3_Sa_c7", Sa, 1'b1);
    check("t3_pend_c7", pend_a, 1'b0);
    step(30);
    Ga = 0; step(1);
    check("t3_Sa_drop", Sa, 1'b0);
    btn_a = 0; step(8);

    // 4: press early in the green -> pending until MIN_GREEN
    btn_a = 1; step(3);
    Ga = 1; step(3);
    check("t4_pend_c3", pend_a, 1'b0);
    step(1);
    check("t4_pend_c4", pend_a, 1'b1);
    step(6);
    check("t4_Sa_c10", Sa, 1'b0);
    check("t4_pend_c10", pend_a, 1'b1);
    step(1);
    check("t4_Sa_c11", Sa, 1'b1);
    check("t4_pend_c11", pend_a, 1'b0);
    step(4);
    Ga = 0; step(1);
    check("t4_Sa_drop", Sa, 1'b0);
    btn_a = 0; step(8);

    // 5: press coincides with the end of the serving green
    Ga = 1; btn_a = 1; step(14);
    check("t5_Sa_on", Sa, 1'b1);
    btn_a = 0; step(8);
    check("t5_Sa_held", Sa, 1'b1);
    btn_a = 1; step(6);
    Ga = 0; step(1);
    check("t5_Sa_fall", Sa, 1'b0);
    check("t5_pend_fall", pend_a, 1'b1);
    Gb = 1; step(5);
    Gb = 0; step(1);
    check("t5_pend_red", pend_a, 1'b1);
    Ga = 1; step(10);
    check("t5_Sa_c10", Sa, 1'b0);
    check("t5_pend_c10", pend_a, 1'b1);
    step(1);
    check("t5_Sa_c11", Sa, 1'b1);
    check("t5_pend_c11", pend_a, 1'b0);
    Ga = 0; btn_a = 0; step(10);

    // 6: random buttons with a toy controller closing the loop
    road = 0; red = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(7) == 0) btn_a = ~btn_a;
      if ($urandom_range(7) == 0) btn_b = ~btn_b;
      if (red) begin
        red = 0;
      end else begin
        sx = (road == 0) ? Sa : Sb;
        if ((sx && $urandom_range(2) == 0) || $urandom_range(99) == 0) begin
          road = 1 - road;
          red  = 1;
        end
      end
      Ga = (road == 0) && !red;
      Gb = (road == 1) && !red;
      if ($urandom_range(999) == 0) begin
        #1 reset = 1'b1;
        model_reset();
        #1 reset = 1'b0;
      end
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
